cpu_io_slave: RTL and testbench

//  CPLD-side responder for the CPU I/O bus (ADS/MIO/WR/addr/data). It synchronises
//   the async strobes and detects I/O cycles (MIO=0). It latches the address and

---
 rtl/cpu_io_slave_if.sv | 28 ++
 rtl/cpu_io_slave.sv | 185 ++++++++++++++++++
 tb/tb_cpu_io_slave.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_io_slave_if.sv
// CPU I/O bus and register-file port bundle for cpu_io_slave.
// slave  : the CPLD responder (drives read data, pad enables and register strobes)
// master : the CPU pins plus the register file (drive strobes/data in, return reg_rdata)
interface cpu_io_slave_if;
    logic        ADS;
    logic        MIO;
    logic        WR;
    logic [2:0]  addr;
    logic [23:0] data_in;
    logic [23:0] data_out;
    logic        data_oe;
    logic        bdir;
    logic [2:0]  reg_addr;
    logic [23:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [23:0] reg_rdata;

    modport slave (
        input  ADS, MIO, WR, addr, data_in, reg_rdata,
        output data_out, data_oe, bdir, reg_addr, reg_wdata, reg_wr, reg_rd
    );

    modport master (
        output ADS, MIO, WR, addr, data_in, reg_rdata,
        input  data_out, data_oe, bdir, reg_addr, reg_wdata, reg_wr, reg_rd
    );
endinterface

// File: rtl/cpu_io_slave.sv
// CPLD-side responder for the CPU I/O bus. Synchronises the async strobes,
// frames I/O cycles (MIO=0), then issues one register write or drives read data.
// Optional read path: define CPU_IO_SLAVE_READ_EN to build reg_rd/data_out/DRIVE;
// without it, reads are only framed and reg_rd/data_oe/bdir/data_out stay 0.
module cpu_io_slave #(
    parameter int SYNC_STAGES  = 2,
    parameter int DATA_SETTLE  = 2,
    parameter int DRIVE_CYCLES = 6
) (
    input logic           clk,
    input logic           rst,
    cpu_io_slave_if.slave bus
);

    // state | meaning
    // IDLE  | no bus cycle in progress, reg_addr holds last value
    // ADDR  | I/O cycle latched, waiting for ADS to return high
    // DATA  | settle timer running; write strobe or read fetch at terminal count
    // DRIVE | read data on the pads for DRIVE_CYCLES clk (read build only)

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRIVE = 2'd3
    } state_t;

    localparam int                SYNC_W    = 30;
    localparam logic [SYNC_W-1:0] SYNC_RST  = {1'b1, 1'b1, 1'b0, 3'd0, 24'd0};
    localparam logic [3:0]        SETTLE_LD = 4'(DATA_SETTLE);
    localparam logic [3:0]        DRIVE_LD  = 4'(DRIVE_CYCLES);

    logic [SYNC_W-1:0] sync_q [SYNC_STAGES];
    logic              s_ads, s_mio, s_wr;
    logic [2:0]        s_addr;
    logic [23:0]       s_data;
    logic              ads_prev;
    logic              start;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        cyc_wr;
    logic [2:0]  addr_q;
    logic        wr_q;
    logic [23:0] wdata_q;

    logic        data_end;
    logic        wr_fire;
    logic        rd_fire;
    logic        drive_on;
`ifdef CPU_IO_SLAVE_READ_EN
    logic        rd_done;
`endif

    assign {s_ads, s_mio, s_wr, s_addr, s_data} = sync_q[SYNC_STAGES-1];
    assign start = ads_prev & ~s_ads & ~s_mio;

    // Bring all CPU pins into the clk domain together so addr/data line up with ADS
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            ads_prev <= 1'b1;
        end else begin
            sync_q[0] <= {bus.ADS, bus.MIO, bus.WR, bus.addr, bus.data_in};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            ads_prev <= s_ads;
        end
    end

    // State register, timer and per-cycle address/direction latch
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            cyc_wr <= 1'b0;
            addr_q <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (start) begin
                cyc_wr <= s_wr;
                addr_q <= s_addr;
            end
        end
    end

    // Next state: a new start wins everywhere, so an in-flight cycle is simply dropped
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (start) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                IDLE: ;
                ADDR: begin
                    if (s_ads) begin
                        state_nxt = DATA;
                        cnt_nxt   = SETTLE_LD;
                    end
                end
                DATA: begin
                    if (cnt <= 4'd1) begin
                        cnt_nxt = cyc_wr ? 4'd0 : DRIVE_LD;
`ifdef CPU_IO_SLAVE_READ_EN
                        state_nxt = cyc_wr ? IDLE : DRIVE;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
`ifdef CPU_IO_SLAVE_READ_EN
                DRIVE: begin
                    if (cnt <= 4'd1) begin
                        state_nxt = IDLE;
                        cnt_nxt   = 4'd0;
                    end else begin
                        cnt_nxt = cnt - 4'd1;
                    end
                end
`endif
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output decode: strobes fire on the decrement that reaches zero, pads follow DRIVE
    always_comb begin
        data_end = ~start & (state == DATA) & (cnt <= 4'd1);
        wr_fire  = data_end & cyc_wr;
        rd_fire  = 1'b0;
        drive_on = 1'b0;
`ifdef CPU_IO_SLAVE_READ_EN
        rd_done  = data_end & ~cyc_wr;
        rd_fire  = ~rst & ~start & (state == ADDR) & s_ads & ~cyc_wr;
        drive_on = (state == DRIVE);
`endif
    end

    // Write strobe and its data launch together so reg_wdata only moves with reg_wr
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= 1'b0;
            wdata_q <= 24'd0;
        end else begin
            wr_q <= wr_fire;
            if (wr_fire) wdata_q <= s_data;
        end
    end

`ifdef CPU_IO_SLAVE_READ_EN
    logic        rd_pend;
    logic [23:0] rd_buf;
    logic [23:0] dout_q;

    // Grab reg_rdata exactly one clk after reg_rd; bypass if settle ends on that clk
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_buf  <= 24'd0;
            dout_q  <= 24'd0;
        end else begin
            rd_pend <= rd_fire;
            if (rd_pend) rd_buf <= bus.reg_rdata;
            if (rd_done) dout_q <= rd_pend ? bus.reg_rdata : rd_buf;
        end
    end

    assign bus.data_out = dout_q;
`else
    logic unused_rdata;
    assign unused_rdata = ^bus.reg_rdata;
    assign bus.data_out = 24'd0;
`endif

    assign bus.reg_addr  = addr_q;
    assign bus.reg_wdata = wdata_q;
    assign bus.reg_wr    = wr_q;
    assign bus.reg_rd    = rd_fire;
    assign bus.data_oe   = drive_on;
    assign bus.bdir      = drive_on;

endmodule

// File: tb/tb_cpu_io_slave.sv
// Directed bench for cpu_io_slave: table of bus cycles plus hand-written
// latency, reset, and abort sequences. Works with or without CPU_IO_SLAVE_READ_EN.
module tb_cpu_io_slave;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cpu_io_slave_if bus ();

    cpu_io_slave #(
        .SYNC_STAGES (2),
        .DATA_SETTLE (2),
        .DRIVE_CYCLES(6)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef CPU_IO_SLAVE_READ_EN
    localparam int RD = 1;
`else
    localparam int RD = 0;
`endif

    typedef struct {
        bit        wr;
        bit        mio;
        bit [2:0]  addr;
        bit [23:0] data;
        int        hi_clks;
        int        exp_wr;
        int        exp_rd;
        int        exp_oe;
        bit [2:0]  exp_addr;
        bit [23:0] exp_wdata;
        bit [23:0] exp_dout;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    int wr_hi    = 0;
    int rd_hi    = 0;
    int oe_hi    = 0;
    int dout_bad = 0;
    int bdir_bad = 0;
    int both_bad = 0;

    logic [23:0] exp_dout = 24'd0;
    logic [26:0] wr_log [$];
    logic [23:0] rd_mem [8];

    // Register-file model: read data appears for exactly one clk after reg_rd
    always @(posedge clk) begin
        bus.reg_rdata <= bus.reg_rd ? rd_mem[bus.reg_addr] : 24'h000000;
    end

    // Mid-cycle monitor of strobes and pad enables
    always @(negedge clk) begin
        if (bus.reg_wr === 1'b1) begin
            wr_hi++;
            wr_log.push_back({bus.reg_addr, bus.reg_wdata});
        end
        if (bus.reg_rd === 1'b1) rd_hi++;
        if (bus.data_oe === 1'b1) begin
            oe_hi++;
            if (bus.data_out !== exp_dout) dout_bad++;
        end
        if (bus.bdir !== bus.data_oe) bdir_bad++;
        if (bus.reg_wr === 1'b1 && bus.reg_rd === 1'b1) both_bad++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bus_cycle(input bit wr, input bit mio, input logic [2:0] a,
                             input logic [23:0] d, input int lo, input int hi);
        bus.MIO     = mio;
        bus.WR      = wr;
        bus.addr    = a;
        bus.data_in = d;
        bus.ADS     = 1'b0;
        repeat (lo) @(negedge clk);
        bus.ADS = 1'b1;
        repeat (hi) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [11];
        int   w0, r0, o0, d0, n;
        bit   found;

        rd_mem[0] = 24'h000000;
        rd_mem[1] = 24'h654321;
        rd_mem[2] = 24'h123456;
        rd_mem[3] = 24'h333333;
        rd_mem[4] = 24'h444444;
        rd_mem[5] = 24'h555555;
        rd_mem[6] = 24'h0A0B0C;
        rd_mem[7] = 24'h777777;

        //        wr    mio   addr  data         hi  ewr erd  eoe    eaddr ewdata        edout
        vt[0]  = '{1'b1, 1'b0, 3'd5, 24'hF7A329, 8,  1,  0,   0,     3'd5, 24'hF7A329, 24'h000000};
        vt[1]  = '{1'b1, 1'b0, 3'd5, 24'hF7A329, 8,  1,  0,   0,     3'd5, 24'hF7A329, 24'h000000};
        vt[2]  = '{1'b1, 1'b0, 3'd5, 24'h0000FF, 8,  1,  0,   0,     3'd5, 24'h0000FF, 24'h000000};
        vt[3]  = '{1'b1, 1'b0, 3'd3, 24'h0000FF, 8,  1,  0,   0,     3'd3, 24'h0000FF, 24'h000000};
        vt[4]  = '{1'b1, 1'b1, 3'd6, 24'h555555, 8,  0,  0,   0,     3'd3, 24'h0000FF, 24'h000000};
        vt[5]  = '{1'b0, 1'b1, 3'd2, 24'h000000, 14, 0,  0,   0,     3'd3, 24'h0000FF, 24'h000000};
        vt[6]  = '{1'b0, 1'b0, 3'd2, 24'h000000, 14, 0,  RD,  6*RD,  3'd2, 24'h0000FF, 24'h123456};
        vt[7]  = '{1'b0, 1'b0, 3'd6, 24'h000000, 14, 0,  RD,  6*RD,  3'd6, 24'h0000FF, 24'h0A0B0C};
        vt[8]  = '{1'b1, 1'b0, 3'd0, 24'h000000, 8,  1,  0,   0,     3'd0, 24'h000000, 24'h000000};
        vt[9]  = '{1'b1, 1'b0, 3'd7, 24'hFFFFFF, 8,  1,  0,   0,     3'd7, 24'hFFFFFF, 24'h000000};
        vt[10] = '{1'b0, 1'b0, 3'd1, 24'h000000, 14, 0,  RD,  6*RD,  3'd1, 24'hFFFFFF, 24'h654321};

        bus.ADS     = 1'b1;
        bus.MIO     = 1'b1;
        bus.WR      = 1'b0;
        bus.addr    = 3'd0;
        bus.data_in = 24'd0;
        rst         = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_reg_wr",    32'(bus.reg_wr),    32'd0);
        check("rst_reg_rd",    32'(bus.reg_rd),    32'd0);
        check("rst_data_oe",   32'(bus.data_oe),   32'd0);
        check("rst_bdir",      32'(bus.bdir),      32'd0);
        check("rst_reg_addr",  32'(bus.reg_addr),  32'd0);
        check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rst_data_out",  32'(bus.data_out),  32'd0);

        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            exp_dout = vt[i].exp_dout;
            w0 = wr_hi; r0 = rd_hi; o0 = oe_hi; d0 = dout_bad;
            bus_cycle(vt[i].wr, vt[i].mio, vt[i].addr, vt[i].data, 4, vt[i].hi_clks);
            check($sformatf("v%0d_wr_cycles", i),  wr_hi - w0,    vt[i].exp_wr);
            check($sformatf("v%0d_rd_cycles", i),  rd_hi - r0,    vt[i].exp_rd);
            check($sformatf("v%0d_oe_cycles", i),  oe_hi - o0,    vt[i].exp_oe);
            check($sformatf("v%0d_dout_bad", i),   dout_bad - d0, 0);
            check($sformatf("v%0d_reg_addr", i),   32'(bus.reg_addr),  32'(vt[i].exp_addr));
            check($sformatf("v%0d_reg_wdata", i),  32'(bus.reg_wdata), 32'(vt[i].exp_wdata));
            check($sformatf("v%0d_oe_idle", i),    32'(bus.data_oe),   32'd0);
        end

        check("wr_log_size", wr_log.size(), 6);
        if (wr_log.size() >= 4) begin
            check("wr_log_1", 32'(wr_log[1]), 32'({3'd5, 24'hF7A329}));
            check("wr_log_2", 32'(wr_log[2]), 32'({3'd5, 24'h0000FF}));
            check("wr_log_3", 32'(wr_log[3]), 32'({3'd3, 24'h0000FF}));
        end

        // Write latency: ADS raised at the pin -> 2 sync clk + DATA_SETTLE + 1
        w0 = wr_hi;
        bus.MIO = 1'b0; bus.WR = 1'b1; bus.addr = 3'd2; bus.data_in = 24'h0C0FFE;
        bus.ADS = 1'b0;
        repeat (4) @(negedge clk);
        bus.ADS = 1'b1;
        n = 0; found = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (!found && bus.reg_wr === 1'b1) begin
                found = 1'b1;
                n = k;
            end
        end
        check("wr_latency",   n, 5);
        check("lat_wr_cycles", wr_hi - w0, 1);
        check("lat_wdata",    32'(bus.reg_wdata), 32'h0C0FFE);

        // Reset pulse during DATA of a write: no strobe, outputs cleared
        w0 = wr_hi;
        bus.WR = 1'b1; bus.addr = 3'd7; bus.data_in = 24'h111111;
        bus.ADS = 1'b0;
        repeat (4) @(negedge clk);
        bus.ADS = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstd_reg_wr",    32'(bus.reg_wr),    32'd0);
        check("rstd_reg_addr",  32'(bus.reg_addr),  32'd0);
        check("rstd_reg_wdata", 32'(bus.reg_wdata), 32'd0);
        check("rstd_data_oe",   32'(bus.data_oe),   32'd0);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("rstd_no_wr", wr_hi - w0, 0);
        w0 = wr_hi;
        bus_cycle(1'b1, 1'b0, 3'd1, 24'hABCDEF, 4, 8);
        check("post_rst_wr_cycles", wr_hi - w0, 1);
        check("post_rst_addr",  32'(bus.reg_addr),  32'd1);
        check("post_rst_wdata", 32'(bus.reg_wdata), 32'hABCDEF);

        // New start during DATA of a write: first cycle dropped, second completes
        w0 = wr_hi; r0 = rd_hi;
        bus.WR = 1'b1; bus.addr = 3'd7; bus.data_in = 24'h222222;
        bus.ADS = 1'b0;
        repeat (4) @(negedge clk);
        bus.ADS = 1'b1;
        @(negedge clk);
        bus_cycle(1'b1, 1'b0, 3'd4, 24'h000001, 4, 8);
        check("abd_wr_cycles", wr_hi - w0, 1);
        check("abd_rd_cycles", rd_hi - r0, 0);
        if (wr_log.size() > 0)
            check("abd_wr_entry", 32'(wr_log[wr_log.size()-1]), 32'({3'd4, 24'h000001}));

`ifdef CPU_IO_SLAVE_READ_EN
        // New start during DRIVE: pads drop on the clk the start takes effect
        w0 = wr_hi; r0 = rd_hi; o0 = oe_hi; d0 = dout_bad;
        exp_dout = 24'h0A0B0C;
        bus.WR = 1'b0; bus.addr = 3'd6; bus.data_in = 24'h0;
        bus.ADS = 1'b0;
        repeat (4) @(negedge clk);
        bus.ADS = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.data_oe === 1'b1) found = 1'b1;
        end
        check("abr_drive_seen", 32'(found), 32'd1);
        bus.WR = 1'b1; bus.addr = 3'd4; bus.data_in = 24'h000001;
        bus.ADS = 1'b0;
        @(negedge clk);
        check("abr_oe_t1", 32'(bus.data_oe), 32'd1);
        @(negedge clk);
        check("abr_oe_t2", 32'(bus.data_oe), 32'd1);
        @(negedge clk);
        check("abr_oe_t3", 32'(bus.data_oe), 32'd0);
        check("abr_bdir_t3", 32'(bus.bdir), 32'd0);
        @(negedge clk);
        bus.ADS = 1'b1;
        repeat (10) @(negedge clk);
        check("abr_oe_cycles", oe_hi - o0, 3);
        check("abr_rd_cycles", rd_hi - r0, 1);
        check("abr_wr_cycles", wr_hi - w0, 1);
        check("abr_dout_bad",  dout_bad - d0, 0);
        if (wr_log.size() > 0)
            check("abr_wr_entry", 32'(wr_log[wr_log.size()-1]), 32'({3'd4, 24'h000001}));
`else
        check("tied_data_out", 32'(bus.data_out), 32'd0);
        check("tied_rd_total", rd_hi, 0);
        check("tied_oe_total", oe_hi, 0);
`endif

        check("bdir_eq_oe", bdir_bad, 0);
        check("wr_rd_excl", both_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
